// File: rtl/mult_rf_pkg.sv
// Shared widths, typedefs and the multiplier stage payload for mult_rf_pipe.
package mult_rf_pkg;

  localparam int unsigned PKG_DATA_W = 16;
  localparam int unsigned PKG_ADDR_W = 3;

  typedef logic [PKG_ADDR_W-1:0]   reg_addr_t;
  typedef logic [PKG_DATA_W-1:0]   data_t;
  typedef logic [2*PKG_DATA_W-1:0] prod_t;

  typedef struct packed {
    logic      valid;
    logic      wb;
    reg_addr_t rd;
    data_t     a;
    data_t     b;
  } stage_t;

endpackage

// File: rtl/mult_rf_pipe_mult_pipe.sv
// One lane's pipelined unsigned multiplier with valid/wb/rd sideband.
module mult_pipe
  import mult_rf_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  stage_t    issue,
  output logic      res_valid,
  output logic      res_wb,
  output reg_addr_t res_rd,
  output prod_t     res_data
);

  stage_t                   s0;
  logic      [STAGES-1:0]   v;
  logic      [STAGES-1:0]   wb;
  reg_addr_t [STAGES-1:0]   rd;
  prod_t     [STAGES-1:0]   p;

  // Stage 0 captures the operands; the product is formed on the way into
  // stage 1 and then shifted down the remaining stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      v  <= '0;
      wb <= '0;
      rd <= '0;
      p  <= '0;
    end else begin
      s0    <= issue;
      v[0]  <= s0.valid;
      wb[0] <= s0.wb;
      rd[0] <= s0.rd;
      p[0]  <= prod_t'(s0.a) * prod_t'(s0.b);
      for (int i = 1; i < int'(STAGES); i++) begin
        v[i]  <= v[i-1];
        wb[i] <= wb[i-1];
        rd[i] <= rd[i-1];
        p[i]  <= p[i-1];
      end
    end
  end

  assign res_valid = v[STAGES-1];
  assign res_wb    = wb[STAGES-1];
  assign res_rd    = rd[STAGES-1];
  assign res_data  = p[STAGES-1];

endmodule

// File: rtl/mult_rf_pipe.sv
// Multi-lane register bank + pipelined multiplier with busy scoreboard and writeback bypass.
module mult_rf_pipe
  import mult_rf_pkg::*;
#(
  parameter int unsigned LANES       = 2,
  parameter int unsigned DATA_W      = PKG_DATA_W,
  parameter int unsigned ADDR_W      = PKG_ADDR_W,
  parameter int unsigned MULT_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LANES-1:0]                  op_valid,
  output logic [LANES-1:0]                  op_ready,
  input  logic [LANES-1:0][ADDR_W-1:0]      op_rs1,
  input  logic [LANES-1:0][ADDR_W-1:0]      op_rs2,
  input  logic [LANES-1:0][ADDR_W-1:0]      op_rd,
  input  logic [LANES-1:0]                  op_wb,
  input  logic [LANES-1:0]                  w_valid,
  input  logic [LANES-1:0][ADDR_W-1:0]      w_addr,
  input  logic [LANES-1:0][DATA_W-1:0]      w_data,
  output logic [LANES-1:0]                  w_err,
  output logic [LANES-1:0]                  res_valid,
  output logic [LANES-1:0][2*DATA_W-1:0]    res_data,
  output logic [LANES-1:0][ADDR_W-1:0]      res_rd
);

  localparam int unsigned REGS = 2**ADDR_W;

  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    logic [REGS-1:0][DATA_W-1:0] bank;
    logic [REGS-1:0]             busy;
    logic                        res_wb;
    logic                        wb_act;
    logic [DATA_W-1:0]           wb_val;
    logic [DATA_W-1:0]           rd_a;
    logic [DATA_W-1:0]           rd_b;
    logic                        hit_a;
    logic                        hit_b;
    logic                        fire;
    logic                        drop;
    logic                        w_err_q;
    stage_t                      issue;

    assign wb_act = res_valid[l] & res_wb;
    assign wb_val = res_data[l][DATA_W-1:0];
    assign hit_a  = wb_act && (res_rd[l] == op_rs1[l]);
    assign hit_b  = wb_act && (res_rd[l] == op_rs2[l]);

    // A busy source is fine when its value is arriving on the bypass this cycle.
    assign op_ready[l] = ~rst & ~(busy[op_rs1[l]] & ~hit_a) & ~(busy[op_rs2[l]] & ~hit_b);
    assign fire        = op_valid[l] & op_ready[l];

    assign rd_a  = hit_a ? wb_val : bank[op_rs1[l]];
    assign rd_b  = hit_b ? wb_val : bank[op_rs2[l]];
    assign issue = '{valid: fire, wb: op_wb[l], rd: op_rd[l], a: rd_a, b: rd_b};

    assign drop     = w_valid[l] & (busy[w_addr[l]] | (wb_act && (res_rd[l] == w_addr[l])));
    assign w_err[l] = w_err_q;

    // Bank, scoreboard and drop flag; a same-edge set of busy overrides the clear.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bank    <= '0;
        busy    <= '0;
        w_err_q <= 1'b0;
      end else begin
        if (wb_act) bank[res_rd[l]] <= wb_val;
        if (w_valid[l] && !drop) bank[w_addr[l]] <= w_data[l];
        if (wb_act) busy[res_rd[l]] <= 1'b0;
        if (fire && op_wb[l]) busy[op_rd[l]] <= 1'b1;
        w_err_q <= drop;
      end
    end

    mult_pipe #(
      .STAGES(MULT_STAGES)
    ) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .issue    (issue),
      .res_valid(res_valid[l]),
      .res_wb   (res_wb),
      .res_rd   (res_rd[l]),
      .res_data (res_data[l])
    );
  end

endmodule

// File: tb/tb_mult_rf_pipe.sv
// Directed self-checking bench for mult_rf_pipe (2 lanes, 16-bit, 2 multiplier stages).
module tb_mult_rf_pipe;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       op_valid, op_ready, op_wb, w_valid, w_err, res_valid;
  logic [1:0][2:0]  op_rs1, op_rs2, op_rd, w_addr, res_rd;
  logic [1:0][15:0] w_data;
  logic [1:0][31:0] res_data;

  int checks   = 0;
  int failures = 0;

  mult_rf_pipe #(.LANES(2), .DATA_W(16), .ADDR_W(3), .MULT_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_rs1(op_rs1), .op_rs2(op_rs2),
    .op_rd(op_rd), .op_wb(op_wb),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_err(w_err),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int l, input int a, input logic [15:0] d);
    w_valid[l] = 1'b1;
    w_addr[l]  = 3'(a);
    w_data[l]  = d;
    cycle();
    w_valid[l] = 1'b0;
  endtask

  task automatic set_op(input int l, input int a, input int b, input int d, input logic wb);
    op_rs1[l]   = 3'(a);
    op_rs2[l]   = 3'(b);
    op_rd[l]    = 3'(d);
    op_wb[l]    = wb;
    op_valid[l] = 1'b1;
  endtask

  // Wait for the result of an op that has just fired; lat counts edges after the issue edge.
  task automatic wait_res(input int l, output logic [31:0] res, output logic [2:0] rdo, output int lat);
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!res_valid[l] && lat < 20);
    res = res_data[l];
    rdo = res_rd[l];
  endtask

  // Issue one op, wait for its result, then let the writeback retire.
  task automatic mul(input int l, input int a, input int b, input int d, input logic wb,
                     output logic [31:0] res, output logic [2:0] rdo, output int lat);
    int n;
    set_op(l, a, b, d, wb);
    #1;
    n = 0;
    while (!op_ready[l] && n < 20) begin
      cycle();
      #1;
      n++;
    end
    cycle();
    op_valid[l] = 1'b0;
    wait_res(l, res, rdo, lat);
    cycle();
  endtask

  logic [31:0] r;
  logic [2:0]  rdo;
  int          lat;
  logic [15:0] rv [2][8];
  int          idx [2];

  initial begin
    rst = 1'b1;
    op_valid = '0; op_wb = '0; op_rs1 = '0; op_rs2 = '0; op_rd = '0;
    w_valid = '0; w_addr = '0; w_data = '0;
    cycle();
    cycle();
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_w_err", 32'(w_err), 32'h0);
    chk("rst_res_data0", res_data[0], 32'h0);
    chk("rst_op_ready", 32'(op_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(op_ready), 32'h3);

    // Basic latency and writeback
    wr(0, 1, 16'h0003);
    wr(0, 2, 16'h0005);
    wr(0, 7, 16'h0001);
    chk("normal_write_no_err", 32'(w_err[0]), 32'h0);
    mul(0, 1, 2, 4, 1'b1, r, rdo, lat);
    chk("basic_data", r, 32'h0000000F);
    chk("basic_rd", 32'(rdo), 32'd4);
    chk("basic_latency", 32'(lat), 32'd2);
    mul(0, 4, 7, 0, 1'b0, r, rdo, lat);
    chk("basic_r4_written", r, 32'h0000000F);

    // RAW hazard: second op stalls until the bypass window
    set_op(0, 1, 2, 4, 1'b1);
    #1;
    chk("raw_first_ready", 32'(op_ready[0]), 32'h1);
    cycle();
    set_op(0, 4, 1, 5, 1'b1);
    #1;
    chk("raw_stall_1", 32'(op_ready[0]), 32'h0);
    cycle();
    #1;
    chk("raw_stall_2", 32'(op_ready[0]), 32'h0);
    cycle();
    chk("raw_first_valid", 32'(res_valid[0]), 32'h1);
    chk("raw_first_data", res_data[0], 32'h0000000F);
    #1;
    chk("raw_bypass_ready", 32'(op_ready[0]), 32'h1);
    cycle();
    op_valid[0] = 1'b0;
    wait_res(0, r, rdo, lat);
    chk("raw_second_data", r, 32'h0000002D);
    chk("raw_second_rd", 32'(rdo), 32'd5);
    chk("raw_second_latency", 32'(lat), 32'd2);
    cycle();

    // Reset while an op is in flight
    set_op(0, 1, 2, 4, 1'b1);
    cycle();
    op_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", 32'(op_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("midrst_no_valid", 32'(res_valid), 32'h0);
    end
    rst = 1'b0;
    op_rs1[0] = 3'd4;
    op_rs2[0] = 3'd4;
    #1;
    chk("midrst_busy_clear", 32'(op_ready[0]), 32'h1);
    cycle();
    chk("midrst_still_no_valid", 32'(res_valid), 32'h0);
    wr(0, 7, 16'h0001);
    mul(0, 4, 7, 0, 1'b0, r, rdo, lat);
    chk("midrst_r4_zero", r, 32'h0);

    // Full-width product and truncated writeback
    wr(0, 1, 16'hFFFF);
    wr(0, 2, 16'hFFFF);
    mul(0, 1, 2, 3, 1'b1, r, rdo, lat);
    chk("trunc_full_prod", r, 32'hFFFE0001);
    mul(0, 3, 7, 0, 1'b0, r, rdo, lat);
    chk("trunc_r3", r, 32'h00000001);

    // External write to a busy register is dropped
    set_op(0, 1, 2, 4, 1'b1);
    cycle();
    op_valid[0] = 1'b0;
    w_valid[0] = 1'b1;
    w_addr[0]  = 3'd4;
    w_data[0]  = 16'h1234;
    cycle();
    w_valid[0] = 1'b0;
    chk("conflict_w_err", 32'(w_err[0]), 32'h1);
    cycle();
    chk("conflict_w_err_pulse", 32'(w_err[0]), 32'h0);
    chk("conflict_res_valid", 32'(res_valid[0]), 32'h1);
    cycle();
    mul(0, 4, 7, 0, 1'b0, r, rdo, lat);
    chk("conflict_r4_kept", r, 32'h00000001);

    // Lane independence: 8 back-to-back issues on both lanes
    for (int i = 0; i < 8; i++) begin
      rv[0][i] = 16'(i + 2);
      rv[1][i] = 16'(16'h0100 + 3 * i);
      w_valid = 2'b11;
      w_addr[0] = 3'(i);
      w_addr[1] = 3'(i);
      w_data[0] = rv[0][i];
      w_data[1] = rv[1][i];
      cycle();
    end
    w_valid = '0;
    idx[0] = 0;
    idx[1] = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        set_op(0, c, (c + 3) % 8, c, 1'b0);
        set_op(1, (c + 5) % 8, c, c, 1'b0);
        #1;
        chk("lanes_ready", 32'(op_ready), 32'h3);
      end else begin
        op_valid = '0;
      end
      cycle();
      for (int l = 0; l < 2; l++) begin
        if (res_valid[l] && idx[l] < 8) begin
          if (l == 0)
            chk("lane0_data", res_data[0], 32'(rv[0][idx[0]]) * 32'(rv[0][(idx[0] + 3) % 8]));
          else
            chk("lane1_data", res_data[1], 32'(rv[1][(idx[1] + 5) % 8]) * 32'(rv[1][idx[1]]));
          chk("lane_rd_order", 32'(res_rd[l]), 32'(idx[l]));
          idx[l]++;
        end
      end
    end
    chk("lane0_count", 32'(idx[0]), 32'd8);
    chk("lane1_count", 32'(idx[1]), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
